// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter and any logic that needs to
// check a ring pattern for legality.
package ring_pkg;

  localparam int         RING_WIDTH_DEFAULT = 4;
  localparam logic [3:0] RING_INIT_DEFAULT  = 4'b0001;

  // True when exactly one of the low w bits of v is set; bits at or above w are ignored.
  function automatic logic is_onehot(input logic [31:0] v, input int w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i < w) && v[i]) begin
        cnt = cnt + 1;
      end
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot ring counter: a single set bit circulates through q, one position per
// clock. Any non-one-hot state is replaced by INIT on the next edge.
module ring_counter
  import ring_pkg::*;
#(
  parameter int               WIDTH    = RING_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT     = WIDTH'(RING_INIT_DEFAULT),
  parameter bit               SHIFT_UP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $fatal(1, "ring_counter: WIDTH must be in 2..32");
  end else if (!is_onehot(32'(INIT), WIDTH)) begin : g_bad_init
    $fatal(1, "ring_counter: INIT must be one-hot within WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] rot;
  logic             legal;

  always_comb begin
    rot = q_q;
    if (SHIFT_UP) begin
      rot = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    end else begin
      rot = {q_q[0], q_q[WIDTH-1:1]};
    end
  end

  // An upset state (zero or several bits set) is not rotated; it is reloaded.
  always_comb begin
    legal = is_onehot(32'(q_q), WIDTH);
    q_d   = INIT;
    if (legal) begin
      q_d = rot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= INIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench for ring_counter: a 4-bit up ring and an 8-bit down ring run
// side by side against an index-based reference model.
module tb_ring_counter;
  import ring_pkg::*;

  localparam int         WA     = 4;
  localparam int         WB     = 8;
  localparam logic [3:0] INIT_A = 4'b0001;
  localparam logic [7:0] INIT_B = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] qa;
  logic [7:0] qb;

  ring_counter #(.WIDTH(WA), .INIT(INIT_A), .SHIFT_UP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .q(qa)
  );
  ring_counter #(.WIDTH(WB), .INIT(INIT_B), .SHIFT_UP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .q(qb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] exp;
    int          ph;
  } exp_t;

  exp_t       sb[$];
  int         total   = 0;
  int         bad     = 0;
  int         disturb = 0;
  logic [3:0] ma;
  logic [3:0] fa;
  logic [7:0] mb;
  logic [7:0] fb;

  // Reference: locate the hot bit and move its index; anything else reloads init.
  function automatic logic [31:0] model_next(input logic [31:0] p, input int w,
                                             input bit up, input logic [31:0] init);
    int idx;
    int n;
    int nidx;
    n   = 0;
    idx = 0;
    for (int i = 0; i < w; i++) begin
      if (p[i]) begin
        n   = n + 1;
        idx = i;
      end
    end
    if (n != 1) return init;
    nidx = up ? ((idx + 1) % w) : ((idx + w - 1) % w);
    return 32'd1 << nidx;
  endfunction

  task automatic push(input bit ut, input logic [3:0] ta, input logic [7:0] tbv, input int ph);
    exp_t e;
    e.id  = 0;
    e.exp = ut ? 32'(ta) : 32'(ma);
    e.ph  = ph;
    sb.push_back(e);
    e.id  = 1;
    e.exp = ut ? 32'(tbv) : 32'(mb);
    sb.push_back(e);
  endtask

  // One clock: model the edge, then (2 units later) change reset / inject upsets
  // and queue what both rings must show at the following falling edge.
  task automatic do_cycle(input logic nr, input bit ia, input logic [3:0] pa,
                          input bit ib, input logic [7:0] pb,
                          input bit ut, input logic [3:0] ta, input logic [7:0] tbv,
                          input int ph);
    @(posedge clk);
    if (rst) begin
      ma = 4'(model_next(32'(ma), WA, 1'b1, 32'(INIT_A)));
      mb = 8'(model_next(32'(mb), WB, 1'b0, 32'(INIT_B)));
    end else begin
      ma = INIT_A;
      mb = INIT_B;
    end
    #2;
    if (!rst || !nr) disturb = disturb + 1;
    rst = nr;
    if (!nr) begin
      ma = INIT_A;
      mb = INIT_B;
    end else if (ia || ib) begin
      disturb = disturb + 1;
      if (ia) begin
        fa = pa;
        force dut_a.q_q = fa;
        ma = pa;
      end
      if (ib) begin
        fb = pb;
        force dut_b.q_q = fb;
        mb = pb;
      end
      #1;
      if (ia) release dut_a.q_q;
      if (ib) release dut_b.q_q;
    end
    push(ut, ta, tbv, ph);
  endtask

  task automatic run(input logic nr, input int ph);
    do_cycle(nr, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, ph);
  endtask

  // Monitor: drains the scoreboard and checks ring invariants at every falling edge.
  exp_t        me;
  logic [31:0] act;
  logic [3:0]  prev_a;
  logic [7:0]  prev_b;
  logic [3:0]  rot_a;
  logic [7:0]  rot_b;
  int          prev_dist = 0;
  bit          prev_ok   = 1'b0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me    = sb.pop_front();
      act   = (me.id == 0) ? 32'(qa) : 32'(qb);
      total = total + 1;
      if (act !== me.exp) begin
        bad = bad + 1;
        $display("FAIL sb_%s ph%0d t=%0t: q=%h expected %h",
                 (me.id == 0) ? "ring4_up" : "ring8_dn", me.ph, $time, act, me.exp);
      end
    end
    if (rst && prev_ok && (prev_dist == disturb)) begin
      total = total + 2;
      if ($countones(qa) != 1) begin
        bad = bad + 1;
        $display("FAIL onehot_ring4 t=%0t: q=%b expected one bit set", $time, qa);
      end
      if ($countones(qb) != 1) begin
        bad = bad + 1;
        $display("FAIL onehot_ring8 t=%0t: q=%b expected one bit set", $time, qb);
      end
      if ($countones(prev_a) == 1) begin
        rot_a = 4'((prev_a << 1) | (prev_a >> 3));
        total = total + 1;
        if (qa !== rot_a) begin
          bad = bad + 1;
          $display("FAIL rotate_ring4 t=%0t: q=%b expected %b", $time, qa, rot_a);
        end
      end
      if ($countones(prev_b) == 1) begin
        rot_b = 8'((prev_b >> 1) | (prev_b << 7));
        total = total + 1;
        if (qb !== rot_b) begin
          bad = bad + 1;
          $display("FAIL rotate_ring8 t=%0t: q=%b expected %b", $time, qb, rot_b);
        end
      end
    end
    prev_a    = qa;
    prev_b    = qb;
    prev_dist = disturb;
    prev_ok   = 1'b1;
  end

  logic [3:0] tab_a [8];
  logic [7:0] tab_b [8];

  initial begin
    int r;
    tab_a = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tab_b = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rst = 1'b0;
    ma  = INIT_A;
    mb  = INIT_B;
    fa  = 4'h0;
    fb  = 8'h00;

    // Reset, release, then eight directed steps.
    @(posedge clk);
    #2;
    push(1'b1, 4'b0001, 8'h01, 0);
    do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 4'b0001, 8'h01, 0);
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, tab_a[i], tab_b[i], 1);
    end

    // Reset asserted between edges while the 4-bit ring shows 0100.
    for (int i = 0; (i < WA) && (ma != 4'b0100); i++) run(1'b1, 2);
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b1, 2);

    // Held in reset across several edges.
    for (int i = 0; i < 6; i++) run(1'b0, 3);
    run(1'b1, 3);
    run(1'b1, 3);

    // Upset recovery: all-zero and two-hot states.
    do_cycle(1'b1, 1'b1, 4'b0000, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00, 4);
    run(1'b1, 4);
    run(1'b1, 4);
    do_cycle(1'b1, 1'b1, 4'b0110, 1'b1, 8'b0110_0000, 1'b0, 4'h0, 8'h00, 4);
    run(1'b1, 4);
    run(1'b1, 4);

    // Long undisturbed run.
    for (int i = 0; i < 1000; i++) run(1'b1, 5);

    // Random reset pulses and random upsets.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        run(1'b0, 6);
      end else if (r < 15) begin
        do_cycle(1'b1, 1'b1, 4'($urandom_range(0, 15)), r[0], 8'($urandom_range(0, 255)),
                 1'b0, 4'h0, 8'h00, 6);
      end else begin
        run(1'b1, 6);
      end
    end

    @(negedge clk);
    #1;
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL sb_drain: entries left=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t expected completion before 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
